// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-sequencer constants: stall vectors, FSM encodings, exception entry PC.
// Also provides the reset-level and zero-word macros used across the CPU.
`ifndef RST_ENABLE
`define RST_ENABLE 1'b0
`endif
`ifndef ZERO_WORD
`define ZERO_WORD 32'h00000000
`endif

package pipe_ctrl_pkg;

    localparam int STALL_BUS = 6;
    typedef logic [STALL_BUS-1:0] stall_t;

    // Bit order {wb,mem,exe,id,if,pc}: each source holds its own stage and everything upstream.
    localparam stall_t STALL_NONE = 6'b000000;
    localparam stall_t STALL_ID   = 6'b000111;
    localparam stall_t STALL_EXE  = 6'b001111;
    localparam stall_t STALL_MEM  = 6'b011111;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_DIV_WAIT = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;

    localparam logic [31:0] EXC_ENTRY_DEFAULT = 32'hBFC00380;

    function automatic stall_t stall_merge(input logic mem, input logic exe, input logic id);
        return (mem ? STALL_MEM : STALL_NONE) |
               (exe ? STALL_EXE : STALL_NONE) |
               (id  ? STALL_ID  : STALL_NONE);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard requests from the pipeline stages and the sequencing controls returned to them.
// master = pipeline side (drives requests), slave = pipe_ctrl side (drives controls).
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic        id_stall_req;
    logic        exe_div_start;
    logic        mem_stall_req;
    logic        mem_exc_valid;
    logic        mem_exc_eret;
    logic [31:0] cp0_epc;

    stall_t      stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        div_busy;
    logic        div_done;
    logic        div_cancel;

    modport master (
        output id_stall_req, exe_div_start, mem_stall_req,
               mem_exc_valid, mem_exc_eret, cp0_epc,
        input  stall, flush, flush_pc, div_busy, div_done, div_cancel
    );

    modport slave (
        input  id_stall_req, exe_div_start, mem_stall_req,
               mem_exc_valid, mem_exc_eret, cp0_epc,
        output stall, flush, flush_pc, div_busy, div_done, div_cancel
    );
endinterface

// File: rtl/pipe_ctrl_divcnt.sv
// Divide-wait down-counter: loads DIV_CYCLES-1 on start, holds at 1 while MEM stalls.
// done/cancel/exe_stall are combinational from the count and the qualified inputs.
module pipe_ctrl_divcnt #(
    parameter int DIV_CYCLES = 34
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic wait_i,
    input  logic exc_i,
    input  logic mem_stall_i,
    output logic exe_stall_o,
    output logic done_o,
    output logic cancel_o
);
    localparam logic [5:0] CNT_LOAD = 6'(DIV_CYCLES - 1);

    logic [5:0] cnt_q, cnt_d;
    logic       last;

    assign last = (cnt_q == 6'd1);

    // The result is only released when EXE can actually advance.
    assign done_o      = wait_i && last && !mem_stall_i && !exc_i;
    assign cancel_o    = exc_i && (wait_i || start_i);
    assign exe_stall_o = start_i || (wait_i && !(last && !mem_stall_i));

    always_comb begin
        cnt_d = cnt_q;
        if (exc_i) begin
            cnt_d = 6'd0;
        end else if (start_i) begin
            cnt_d = CNT_LOAD;
        end else if (wait_i) begin
            if (cnt_q > 6'd1)
                cnt_d = cnt_q - 6'd1;
            else if (!mem_stall_i)
                cnt_d = 6'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == `RST_ENABLE)
            cnt_q <= 6'd0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges ID/EXE/MEM stall requests, turns MEM exceptions/ERET into a
// one-cycle flush + redirect; outputs are same-cycle. PIPE_CTRL_PERF_EN adds perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          DIV_CYCLES = 34,
    parameter logic [31:0] EXC_ENTRY  = EXC_ENTRY_DEFAULT
) (
    input  logic       cpu_clk_50M,
    input  logic       cpu_rst_n,
    pipe_ctrl_if.slave pif
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_div_cyc
`endif
);
    logic [1:0] state_q, state_d;
    logic       exc_act, start_act, in_wait;
    logic       exe_stall, div_done, div_cancel;
    stall_t     stall;

    // Anything arriving during FLUSH belongs to a squashed instruction.
    assign exc_act   = pif.mem_exc_valid && (state_q != ST_FLUSH);
    assign start_act = pif.exe_div_start && (state_q == ST_RUN);
    assign in_wait   = (state_q == ST_DIV_WAIT);

    pipe_ctrl_divcnt #(.DIV_CYCLES(DIV_CYCLES)) u_divcnt (
        .clk         (cpu_clk_50M),
        .rst_n       (cpu_rst_n),
        .start_i     (start_act),
        .wait_i      (in_wait),
        .exc_i       (exc_act),
        .mem_stall_i (pif.mem_stall_req),
        .exe_stall_o (exe_stall),
        .done_o      (div_done),
        .cancel_o    (div_cancel)
    );

    always_comb begin
        stall = STALL_NONE;
        if (!exc_act) begin
            if (state_q == ST_FLUSH)
                stall = stall_merge(pif.mem_stall_req, 1'b0, 1'b0);
            else
                stall = stall_merge(pif.mem_stall_req, exe_stall, pif.id_stall_req);
        end
    end

    always_comb begin
        state_d = state_q;
        if (exc_act) begin
            state_d = ST_FLUSH;
        end else begin
            case (state_q)
                ST_RUN:      if (start_act) state_d = ST_DIV_WAIT;
                ST_DIV_WAIT: if (div_done)  state_d = ST_RUN;
                default:     state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (cpu_rst_n == `RST_ENABLE)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

    assign pif.stall      = stall;
    assign pif.flush      = exc_act;
    assign pif.flush_pc   = exc_act ? (pif.mem_exc_eret ? pif.cp0_epc : EXC_ENTRY) : `ZERO_WORD;
    assign pif.div_busy   = in_wait;
    assign pif.div_done   = div_done;
    assign pif.div_cancel = div_cancel;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q, perf_div_q;

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (cpu_rst_n == `RST_ENABLE) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
            perf_div_q   <= 32'd0;
        end else begin
            if ((stall != STALL_NONE) && (perf_stall_q != 32'hFFFFFFFF))
                perf_stall_q <= perf_stall_q + 32'd1;
            if (exc_act && (perf_flush_q != 32'hFFFFFFFF))
                perf_flush_q <= perf_flush_q + 32'd1;
            if (in_wait && (perf_div_q != 32'hFFFFFFFF))
                perf_div_q <= perf_div_q + 32'd1;
        end
    end

    assign perf_stall_cyc = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
    assign perf_div_cyc   = perf_div_q;
`endif
endmodule
